// File: rtl/mi_pipeline_pkg.sv
// Shared widths, FSM states and force saturation
// for the mass/link simulation pipeline.
package mi_pipeline_pkg;

  localparam int SIZE       = 27;
  localparam int ADDR_WIDTH = 4;
  localparam int LINK_WIDTH = 4;
  localparam int K_WIDTH    = 18;
  localparam int FRAC       = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } state_t;

  // clamp v to the signed range of a w-bit word
  function automatic logic signed [63:0] sat_force(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/link_force_sequencer_if.sv
// Force record stream from the link sequencer
// to the force-accumulation stage.
interface link_force_sequencer_if #(
  parameter int SIZE       = mi_pipeline_pkg::SIZE,
  parameter int ADDR_WIDTH = mi_pipeline_pkg::ADDR_WIDTH
);

  logic                         out_valid;
  logic                         out_ready;
  logic        [ADDR_WIDTH-1:0] out_mass_a;
  logic        [ADDR_WIDTH-1:0] out_mass_b;
  logic signed [SIZE-1:0]       out_force;

  modport master (
    output out_valid,
    output out_mass_a,
    output out_mass_b,
    output out_force,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_mass_a,
    input  out_mass_b,
    input  out_force,
    output out_ready
  );

endinterface

// File: rtl/link_force_sequencer_table.sv
// Link table: register array, one sync write port,
// one async read port, cleared on reset.
module link_table #(
  parameter int LINK_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int K_WIDTH    = 18
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [LINK_WIDTH-1:0]     waddr,
  input  logic [ADDR_WIDTH-1:0]     wmass_a,
  input  logic [ADDR_WIDTH-1:0]     wmass_b,
  input  logic signed [K_WIDTH-1:0] wk,
  input  logic [LINK_WIDTH-1:0]     raddr,
  output logic [ADDR_WIDTH-1:0]     rmass_a,
  output logic [ADDR_WIDTH-1:0]     rmass_b,
  output logic signed [K_WIDTH-1:0] rk
);

  localparam int DEPTH = 1 << LINK_WIDTH;

  logic        [ADDR_WIDTH-1:0] a_mem [DEPTH];
  logic        [ADDR_WIDTH-1:0] b_mem [DEPTH];
  logic signed [K_WIDTH-1:0]    k_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
        k_mem[i] <= '0;
      end
    end else if (we) begin
      a_mem[waddr] <= wmass_a;
      b_mem[waddr] <= wmass_b;
      k_mem[waddr] <= wk;
    end
  end

  assign rmass_a = a_mem[raddr];
  assign rmass_b = b_mem[raddr];
  assign rk      = k_mem[raddr];

endmodule

// File: rtl/link_force_sequencer.sv
// Walks the link table once per tick, reads both
// endpoint positions and streams saturated spring forces.
module link_force_sequencer #(
  parameter int SIZE       = mi_pipeline_pkg::SIZE,
  parameter int ADDR_WIDTH = mi_pipeline_pkg::ADDR_WIDTH,
  parameter int LINK_WIDTH = mi_pipeline_pkg::LINK_WIDTH,
  parameter int K_WIDTH    = mi_pipeline_pkg::K_WIDTH,
  parameter int FRAC       = mi_pipeline_pkg::FRAC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LINK_WIDTH:0]       n_links,
  input  logic                      cfg_we,
  input  logic [LINK_WIDTH-1:0]     cfg_addr,
  input  logic [ADDR_WIDTH-1:0]     cfg_mass_a,
  input  logic [ADDR_WIDTH-1:0]     cfg_mass_b,
  input  logic signed [K_WIDTH-1:0] cfg_k,
  output logic [ADDR_WIDTH-1:0]     r_addr_q1,
  output logic [ADDR_WIDTH-1:0]     r_addr_q2,
  input  logic signed [SIZE-1:0]    q1,
  input  logic signed [SIZE-1:0]    q2,
  link_force_sequencer_if.master    rec,
  output logic                      busy,
  output logic                      done
);

  import mi_pipeline_pkg::*;

  localparam int PW = SIZE + K_WIDTH + 1;

  state_t state;
  state_t state_d;

  logic [LINK_WIDTH-1:0] idx;
  logic [LINK_WIDTH:0]   n_lat;
  logic                  last;
  logic                  run;
  logic                  stall;

  logic        [ADDR_WIDTH-1:0] t_a;
  logic        [ADDR_WIDTH-1:0] t_b;
  logic signed [K_WIDTH-1:0]    t_k;

  logic                         s1_valid;
  logic signed [SIZE:0]         s1_diff;
  logic signed [K_WIDTH-1:0]    s1_k;
  logic        [ADDR_WIDTH-1:0] s1_a;
  logic        [ADDR_WIDTH-1:0] s1_b;

  logic signed [SIZE:0]      diff_d;
  logic signed [PW-1:0]      prod;
  logic signed [PW-1:0]      shifted;
  logic signed [SIZE-1:0]    force_d;

  assign run   = (state == RUN);
  assign busy  = (state == RUN) || (state == DRAIN);
  assign done  = (state == FINISH);
  assign stall = rec.out_valid & ~rec.out_ready;
  assign last  = ({1'b0, idx} == (n_lat - 1'b1));

  link_table #(
    .LINK_WIDTH (LINK_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .K_WIDTH    (K_WIDTH)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we & ~busy),
    .waddr   (cfg_addr),
    .wmass_a (cfg_mass_a),
    .wmass_b (cfg_mass_b),
    .wk      (cfg_k),
    .raddr   (idx),
    .rmass_a (t_a),
    .rmass_b (t_b),
    .rk      (t_k)
  );

  assign r_addr_q1 = run ? t_a : '0;
  assign r_addr_q2 = run ? t_b : '0;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (start)
          state_d = (n_links == '0) ? FINISH : RUN;
      RUN:
        if (!stall && last)
          state_d = DRAIN;
      DRAIN:
        if (rec.out_valid && rec.out_ready && !s1_valid)
          state_d = FINISH;
      FINISH:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_d;
  end

  // counter only steps on cycles where the pipe advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      n_lat <= '0;
    end else if (state == IDLE && start) begin
      idx   <= '0;
      n_lat <= n_links;
    end else if (run && !stall && !last) begin
      idx <= idx + 1'b1;
    end
  end

  assign diff_d = {q2[SIZE-1], q2} - {q1[SIZE-1], q1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_k     <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (!stall) begin
      s1_valid <= run;
      if (run) begin
        s1_diff <= diff_d;
        s1_k    <= t_k;
        s1_a    <= t_a;
        s1_b    <= t_b;
      end
    end
  end

  assign prod    = PW'(s1_diff) * PW'(s1_k);
  assign shifted = prod >>> FRAC;
  assign force_d = SIZE'(sat_force(64'(shifted), SIZE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec.out_valid  <= 1'b0;
      rec.out_mass_a <= '0;
      rec.out_mass_b <= '0;
      rec.out_force  <= '0;
    end else if (!stall) begin
      rec.out_valid <= s1_valid;
      if (s1_valid) begin
        rec.out_mass_a <= s1_a;
        rec.out_mass_b <= s1_b;
        rec.out_force  <= force_d;
      end
    end
  end

endmodule

// File: tb/tb_link_force_sequencer.sv
// Randomized bench for link_force_sequencer against
// an arithmetic reference model of the force records.
module tb_link_force_sequencer;

  import mi_pipeline_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n;
  logic                      start;
  logic [LINK_WIDTH:0]       n_links;
  logic                      cfg_we;
  logic [LINK_WIDTH-1:0]     cfg_addr;
  logic [ADDR_WIDTH-1:0]     cfg_mass_a;
  logic [ADDR_WIDTH-1:0]     cfg_mass_b;
  logic signed [K_WIDTH-1:0] cfg_k;
  logic [ADDR_WIDTH-1:0]     r_addr_q1;
  logic [ADDR_WIDTH-1:0]     r_addr_q2;
  logic signed [SIZE-1:0]    q1;
  logic signed [SIZE-1:0]    q2;
  logic                      busy;
  logic                      done;

  link_force_sequencer_if rec ();

  link_force_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_links    (n_links),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_mass_a (cfg_mass_a),
    .cfg_mass_b (cfg_mass_b),
    .cfg_k      (cfg_k),
    .r_addr_q1  (r_addr_q1),
    .r_addr_q2  (r_addr_q2),
    .q1         (q1),
    .q2         (q2),
    .rec        (rec),
    .busy       (busy),
    .done       (done)
  );

  logic signed [SIZE-1:0] xram [16];
  assign q1 = xram[r_addr_q1];
  assign q2 = xram[r_addr_q2];

  int     ma [16];
  int     mb [16];
  longint mk [16];

  typedef struct {
    int     a;
    int     b;
    longint f;
  } rec_t;

  rec_t exp_q [$];

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_force(input longint xa, input longint xb, input longint k);
    longint p;
    longint hi;
    longint lo;
    hi = (64'sd1 <<< 26) - 1;
    lo = -(64'sd1 <<< 26);
    p  = ((xb - xa) * k) >>> 16;
    if (p > hi) p = hi;
    if (p < lo) p = lo;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int i, input int a, input int b, input longint k);
    cfg_we     = 1'b1;
    cfg_addr   = i[3:0];
    cfg_mass_a = a[3:0];
    cfg_mass_b = b[3:0];
    cfg_k      = k[17:0];
    step();
    cfg_we = 1'b0;
    ma[i]  = a;
    mb[i]  = b;
    mk[i]  = k;
  endtask

  task automatic rand_entry(input int i);
    write_entry(i, $urandom_range(0, 15), $urandom_range(0, 15),
                longint'($urandom_range(0, 262143)) - 131072);
  endtask

  task automatic rand_ram();
    for (int j = 0; j < 16; j++)
      xram[j] = 27'($urandom);
  endtask

  task automatic run_tick(input int n, input int st_from, input int st_len, input bit inject);
    int   done_cyc;
    int   first_v;
    int   nrec;
    rec_t e;
    done_cyc = -1;
    first_v  = -1;
    nrec     = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      e.a = ma[i];
      e.b = mb[i];
      e.f = ref_force(longint'(xram[ma[i]]), longint'(xram[mb[i]]), mk[i]);
      exp_q.push_back(e);
    end
    start   = 1'b1;
    n_links = 5'(n);
    step();
    start = 1'b0;
    for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
      rec.out_ready = !(c >= st_from && c < st_from + st_len);
      if (inject && c == 2) begin
        start      = 1'b1;
        n_links    = 5'd1;
        cfg_we     = 1'b1;
        cfg_addr   = '0;
        cfg_mass_a = 4'($urandom);
        cfg_mass_b = 4'($urandom);
        cfg_k      = 18'($urandom);
      end
      @(negedge clk);
      if (c == 1 && n > 0) begin
        chk("addr_a_c1", r_addr_q1, ma[0]);
        chk("addr_b_c1", r_addr_q2, mb[0]);
      end
      if (rec.out_valid && first_v < 0)
        first_v = c;
      if (rec.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_rec", 1, 0);
        end else begin
          chk("mass_a", rec.out_mass_a, exp_q[0].a);
          chk("mass_b", rec.out_mass_b, exp_q[0].b);
          chk("force", rec.out_force, exp_q[0].f);
          if (rec.out_ready) begin
            void'(exp_q.pop_front());
            nrec++;
          end
        end
      end
      if (done) begin
        done_cyc = c;
        chk("busy_finish", busy, 0);
      end else begin
        chk("busy", busy, n != 0);
      end
      step();
      start  = 1'b0;
      cfg_we = 1'b0;
    end
    rec.out_ready = 1'b1;
    chk("done_cycle", done_cyc, (n == 0) ? 1 : n + 3 + st_len);
    chk("records", nrec, n);
    chk("leftover", exp_q.size(), 0);
    if (n == 0)
      chk("no_valid", first_v, -1);
    else if (st_from != 3)
      chk("first_valid", first_v, 3);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_valid", rec.out_valid, 0);
    step();
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    n_links       = '0;
    cfg_we        = 1'b0;
    cfg_addr      = '0;
    cfg_mass_a    = '0;
    cfg_mass_b    = '0;
    cfg_k         = '0;
    rec.out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      xram[j] = '0;
      ma[j]   = 0;
      mb[j]   = 0;
      mk[j]   = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rec.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", r_addr_q1, 0);
    chk("rst_force", rec.out_force, 0);
    step();
    rst_n = 1'b1;
    step();

    write_entry(0, 2, 5, 32768);
    xram[2] = 27'sd1000;
    xram[5] = 27'sd3000;
    run_tick(1, 0, 0, 1'b0);

    write_entry(0, 1, 3, 32768);
    xram[1] = 27'sd3;
    xram[3] = 27'sd0;
    run_tick(1, 0, 0, 1'b0);
    write_entry(0, 1, 3, -65536);
    run_tick(1, 0, 0, 1'b0);

    xram[6] = {1'b0, {26{1'b1}}};
    xram[7] = {1'b1, 26'd0};
    write_entry(0, 7, 6, 131071);
    run_tick(1, 0, 0, 1'b0);
    write_entry(0, 7, 6, -131072);
    run_tick(1, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++)
      rand_entry(i);
    rand_ram();
    run_tick(4, 3, 4, 1'b0);

    run_tick(0, 0, 0, 1'b0);

    for (int i = 0; i < 16; i++)
      rand_entry(i);
    rand_ram();
    run_tick(16, 0, 0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 16);
      rand_entry($urandom_range(0, 15));
      rand_ram();
      run_tick(n, $urandom_range(3, n + 2), $urandom_range(0, 5), 1'b0);
    end

    start   = 1'b1;
    n_links = 5'd8;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_valid", rec.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", rec.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_addr_a", r_addr_q1, 0);
    chk("arst_addr_b", r_addr_q2, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 16; j++) begin
      ma[j] = 0;
      mb[j] = 0;
      mk[j] = 0;
    end
    rand_ram();
    step();
    run_tick(4, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
